obs_scheduler: RTL and testbench

// - Owns obstacle slots for the dino game: spawns obstacles at random intervals, scrolls them

---
 rtl/obs_pkg.sv | 43 ++++
 rtl/obs_lfsr.sv | 18 +
 rtl/obs_scheduler.sv | 179 +++++++++++++++++
 tb/tb_obs_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/obs_pkg.sv
// Shared definitions for the obstacle scheduler: obstacle type encodings,
// sprite geometry, per-type vertical offsets and LFSR constants.
package obs_pkg;

  typedef enum logic [2:0] {
    OBS_EMPTY   = 3'b000,
    CAC_3       = 3'b001,
    CAC_2       = 3'b010,
    CAC_THICK_1 = 3'b011,
    CAC_THICK_2 = 3'b100,
    CAC_THIN    = 3'b101,
    BIRD_LOW    = 3'b110,
    BIRD_HIGH   = 3'b111
  } obs_type_e;

  typedef enum logic {ST_IDLE, ST_RUN} ctl_state_e;

  // Registered pixel response towards the sprite ROM.
  typedef struct packed {
    logic [2:0] typ;
    logic [2:0] cnt;
  } pix_rsp_t;

  localparam int SPR_W = 16;
  localparam int SPR_H = 32;

  // Distance from the ground line up to the sprite's top row.
  localparam logic [10:0] CAC_Y_OFF       = 11'd32;
  localparam logic [10:0] BIRD_LOW_Y_OFF  = 11'd56;
  localparam logic [10:0] BIRD_HIGH_Y_OFF = 11'd88;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  function automatic logic [10:0] sprite_top(input logic [2:0] typ,
                                             input logic [10:0] ground);
    case (typ)
      BIRD_LOW:  sprite_top = ground - BIRD_LOW_Y_OFF;
      BIRD_HIGH: sprite_top = ground - BIRD_HIGH_Y_OFF;
      default:   sprite_top = ground - CAC_Y_OFF;
    endcase
  endfunction

endpackage

// File: rtl/obs_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left with the feedback
// bit entering at [0]. Loads LFSR_SEED on reset, advances only when en=1.
// Ports: clk, rst_n (async low), en, q (current state).
module obs_lfsr
  import obs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= LFSR_SEED;
    else if (en) q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/obs_scheduler.sv
// Obstacle slot owner for the dino game. Spawns obstacles at pseudo-random
// frame intervals, scrolls them left once per frame, retires them at the
// left edge, and per pixel selects the covering obstacle for the sprite ROM.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_frame_tick    1-cycle pulse per frame
//   i_game_run      game running; low clears all slots
//   i_speed         scroll px per frame
//   i_hpos, i_vpos  current pixel
//   o_rom_counter   {row[1:0], col} sprite cell index (1 clk latency)
//   o_obs_type      obstacle type at pixel, 0 when none (1 clk latency)
//   o_obs_passed    1-cycle pulse when any obstacle retires
module obs_scheduler
  import obs_pkg::*;
#(
  parameter int NUM_SLOTS  = 2,
  parameter int SCREEN_W   = 640,
  parameter int GROUND_Y   = 400,
  parameter int CELL_SHIFT = 3,
  parameter int FIRST_GAP  = 60,
  parameter int MIN_GAP    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_tick,
  input  logic       i_game_run,
  input  logic [3:0] i_speed,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  output logic [2:0] o_rom_counter,
  output logic [2:0] o_obs_type,
  output logic       o_obs_passed
);

  localparam int TMR_W = 8;
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  ctl_state_e state, state_nxt;

  logic [NUM_SLOTS-1:0]             slot_vld, vld_n;
  logic [NUM_SLOTS-1:0][10:0]       slot_x, x_n;
  logic [NUM_SLOTS-1:0][2:0]        slot_type, type_n;
  logic [TMR_W-1:0]                 timer, timer_n;
  logic                             passed_n;
  logic [7:0]                       lfsr;
  logic                             run_tick;
  logic                             free_found;
  logic [IDX_W-1:0]                 free_idx;
  logic [2:0]                       spawn_type;
  logic [10:0]                      spd, hpos, vpos, ground;
  logic [NUM_SLOTS-1:0]             hit;
  logic [NUM_SLOTS-1:0][2:0]        hit_cnt;
  pix_rsp_t                         pix, pix_n;

  assign spd    = {7'd0, i_speed};
  assign hpos   = {1'b0, i_hpos};
  assign vpos   = {1'b0, i_vpos};
  assign ground = 11'(GROUND_Y);

  assign run_tick = (state == ST_RUN) && i_game_run && i_frame_tick;

  obs_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_tick),
    .q     (lfsr)
  );

  // Type 000 is reserved for "no obstacle", so fold it onto CAC_3.
  assign spawn_type = (lfsr[2:0] == 3'b000) ? 3'(CAC_3) : lfsr[2:0];

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_game_run)  state_nxt = ST_RUN;
      ST_RUN:  if (!i_game_run) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- slot / spawn update ----------------
  always_comb begin
    vld_n      = slot_vld;
    x_n        = slot_x;
    type_n     = slot_type;
    timer_n    = timer;
    passed_n   = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;

    // Lowest slot that is free before this tick; slots retiring on this
    // tick are deliberately not eligible until the next one.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_vld[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end

    if (!i_game_run) begin
      vld_n = '0;
    end else if (state == ST_IDLE) begin
      timer_n = TMR_W'(FIRST_GAP);
    end else if (i_frame_tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slot_vld[i]) begin
          if (slot_x[i] < spd) begin
            vld_n[i] = 1'b0;
            passed_n = 1'b1;
          end else begin
            x_n[i] = slot_x[i] - spd;
          end
        end
      end
      if (timer != '0) begin
        timer_n = timer - TMR_W'(1);
      end else if (free_found) begin
        vld_n[free_idx]  = 1'b1;
        x_n[free_idx]    = 11'(SCREEN_W);
        type_n[free_idx] = spawn_type;
        timer_n          = TMR_W'(MIN_GAP) + TMR_W'(lfsr[7:3]);
      end
      // timer == 0 with no free slot: hold at 0 and retry next tick
    end
  end

  // ---------------- pixel hit test ----------------
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    logic [10:0] top, dx, dy;
    assign top = sprite_top(slot_type[g], ground);
    assign dx  = hpos - slot_x[g];
    assign dy  = vpos - top;
    // The >= guards make dx/dy valid offsets, so upper bounds are just < size.
    assign hit[g] = slot_vld[g] && (hpos >= slot_x[g]) && (dx < 11'(SPR_W)) &&
                    (vpos >= top) && (dy < 11'(SPR_H));
    assign hit_cnt[g] = {dy[CELL_SHIFT+1:CELL_SHIFT], dx[CELL_SHIFT]};
  end

  always_comb begin
    pix_n = '0;
    // Walk downwards so the lowest-index hit overwrites the others.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pix_n.typ = slot_type[i];
        pix_n.cnt = hit_cnt[i];
      end
    end
    if (!i_game_run) pix_n = '0;
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld     <= '0;
      slot_x       <= '0;
      slot_type    <= '0;
      timer        <= TMR_W'(FIRST_GAP);
      pix          <= '0;
      o_obs_passed <= 1'b0;
    end else begin
      slot_vld     <= vld_n;
      slot_x       <= x_n;
      slot_type    <= type_n;
      timer        <= timer_n;
      pix          <= pix_n;
      o_obs_passed <= passed_n;
    end
  end

  assign o_obs_type    = pix.typ;
  assign o_rom_counter = pix.cnt;

endmodule

// File: tb/tb_obs_scheduler.sv
// Randomized bench for obs_scheduler against a frame-level reference model
// of the obstacle slots, spawn timer and LFSR.
module tb_obs_scheduler;

  localparam int NS = 2;
  localparam int GY = 400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_frame_tick, i_game_run;
  logic [3:0] i_speed;
  logic [9:0] i_hpos, i_vpos;
  logic [2:0] o_rom_counter, o_obs_type;
  logic       o_obs_passed;

  obs_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_tick  (i_frame_tick),
    .i_game_run    (i_game_run),
    .i_speed       (i_speed),
    .i_hpos        (i_hpos),
    .i_vpos        (i_vpos),
    .o_rom_counter (o_rom_counter),
    .o_obs_type    (o_obs_type),
    .o_obs_passed  (o_obs_passed)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // reference model
  bit m_run;
  bit m_vld[NS];
  int m_x[NS], m_type[NS];
  int m_timer, m_lfsr;
  int exp_type, exp_cnt, exp_pass;
  int n_pass_seen, n_hits_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int top_of(input int t);
    if (t == 6) return GY - 56;
    if (t == 7) return GY - 88;
    return GY - 32;
  endfunction

  function automatic int lfsr_next(input int l);
    logic [7:0] v;
    v = l[7:0];
    return int'({v[6:0], ^(v & 8'hB8)});
  endfunction

  task automatic model_reset();
    m_run = 0;
    for (int i = 0; i < NS; i++) begin m_vld[i] = 0; m_x[i] = 0; m_type[i] = 0; end
    m_timer = 60;
    m_lfsr  = 8'hA5;
  endtask

  task automatic pix_expect(input int h, input int v, input bit run);
    exp_type = 0; exp_cnt = 0;
    if (run) begin
      for (int i = 0; i < NS; i++) begin
        int t;
        t = top_of(m_type[i]);
        if (m_vld[i] && h >= m_x[i] && h < m_x[i] + 16 && v >= t && v < t + 32) begin
          exp_type = m_type[i];
          exp_cnt  = (((v - t) / 8) % 4) * 2 + ((h - m_x[i]) / 8) % 2;
          break;
        end
      end
    end
  endtask

  task automatic model_edge(input bit tick, input bit run);
    exp_pass = 0;
    if (!m_run) begin
      if (run) begin m_run = 1; m_timer = 60; end
    end else if (!run) begin
      m_run = 0;
      for (int i = 0; i < NS; i++) m_vld[i] = 0;
    end else if (tick) begin
      int fr;
      fr = -1;
      for (int i = 0; i < NS; i++) if (!m_vld[i] && fr < 0) fr = i;
      for (int i = 0; i < NS; i++) begin
        if (m_vld[i]) begin
          if (m_x[i] < int'(i_speed)) begin m_vld[i] = 0; exp_pass = 1; end
          else m_x[i] = m_x[i] - int'(i_speed);
        end
      end
      if (m_timer > 0) m_timer--;
      else if (fr >= 0) begin
        m_vld[fr]  = 1;
        m_x[fr]    = 640;
        m_type[fr] = (m_lfsr % 8 == 0) ? 1 : m_lfsr % 8;
        m_timer    = 24 + m_lfsr / 8;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  // One clock. h < 0 picks a pixel at random, often inside a live obstacle.
  task automatic cyc(input bit tick, input bit run, input int h, input int v);
    int hh, vv, j;
    hh = h; vv = v;
    if (hh < 0) begin
      j = int'($urandom_range(0, NS - 1));
      if ($urandom_range(0, 1) == 1 && m_vld[j]) begin
        hh = m_x[j] + int'($urandom_range(0, 19)) - 2;
        vv = top_of(m_type[j]) + int'($urandom_range(0, 35)) - 2;
      end else begin
        hh = int'($urandom_range(0, 1023));
        vv = int'($urandom_range(0, 1023));
      end
    end
    i_hpos = hh[9:0];
    i_vpos = vv[9:0];
    i_frame_tick = tick;
    i_game_run   = run;
    pix_expect(int'(i_hpos), int'(i_vpos), run);
    model_edge(tick, run);
    @(posedge clk); #1;
    chk("obs_type", o_obs_type, exp_type);
    chk("rom_counter", o_rom_counter, exp_cnt);
    chk("obs_passed", o_obs_passed, exp_pass);
    if (o_obs_passed) n_pass_seen++;
    if (exp_type != 0) n_hits_seen++;
    i_frame_tick = 1'b0;
  endtask

  task automatic state_chk();
    for (int i = 0; i < NS; i++) begin
      chk("slot_vld", dut.slot_vld[i], m_vld[i]);
      if (m_vld[i]) begin
        chk("slot_x", dut.slot_x[i], m_x[i]);
        chk("slot_type", dut.slot_type[i], m_type[i]);
      end
    end
    chk("timer", dut.timer, m_timer);
  endtask

  // One frame: tick cycle plus a few random pixel cycles.
  task automatic frame();
    cyc(1'b1, 1'b1, -1, 0);
    state_chk();
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, -1, 0);
  endtask

  initial begin
    rst_n = 1'b0; i_frame_tick = 1'b0; i_game_run = 1'b0; i_speed = 4'd4;
    i_hpos = '0; i_vpos = '0;
    n_pass_seen = 0; n_hits_seen = 0;
    model_reset();
    #12;
    chk("rst_type", o_obs_type, 0);
    chk("rst_counter", o_rom_counter, 0);
    chk("rst_passed", o_obs_passed, 0);
    chk("rst_timer", dut.timer, 60);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // start game, 60 frames with no spawn
    cyc(1'b0, 1'b1, -1, 0);
    for (int f = 0; f < 60; f++) frame();
    chk("no_spawn_60", dut.slot_vld, 0);
    frame();
    chk("spawn61_vld", dut.slot_vld[0], 1);
    chk("spawn61_x", dut.slot_x[0], 640);

    // frozen: slot1 eventually spawns at the same x, overlapping slot0
    i_speed = 4'd0;
    for (int f = 0; f < 60; f++) frame();
    chk("frozen_x", dut.slot_x[0], 640);
    cyc(1'b0, 1'b1, 645, top_of(m_type[0]) + 5);
    chk("overlap_slot0", o_obs_type, m_type[0]);

    // speed 4 for 5 frames: 640 - 20
    i_speed = 4'd4;
    for (int f = 0; f < 5; f++) frame();
    chk("scroll_620", dut.slot_x[0], 620);

    // randomized run with speed changes; exercises full slots and retirement
    for (int f = 0; f < 500; f++) begin
      if (f % 25 == 0) i_speed = 4'($urandom_range(0, 15));
      frame();
    end

    // game_run drop while pointing at a live obstacle
    for (int f = 0; f < 200 && !(m_vld[0] && m_x[0] < 1000); f++) frame();
    cyc(1'b0, 1'b1, m_x[0] + 9, top_of(m_type[0]) + 17);
    chk("pre_drop_hit", o_obs_type, m_type[0]);
    cyc(1'b0, 1'b0, m_x[0] + 9, top_of(m_type[0]) + 17);
    chk("drop_empty", o_obs_type, 0);
    state_chk();

    // restart and run to a live obstacle, then reset mid-cycle
    cyc(1'b0, 1'b1, -1, 0);
    i_speed = 4'd8;
    for (int f = 0; f < 200 && !(m_vld[0] && m_x[0] < 1000); f++) frame();
    cyc(1'b0, 1'b1, m_x[0] + 1, top_of(m_type[0]) + 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_type", o_obs_type, 0);
    chk("async_rst_cnt", o_rom_counter, 0);
    chk("async_rst_vld", dut.slot_vld, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, -1, 0);
    for (int f = 0; f < 70; f++) frame();

    chk("saw_retire", (n_pass_seen > 0), 1);
    chk("saw_hits", (n_hits_seen > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
